// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef enum logic {RUN, FLUSH} fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Redirect, instruction-memory and decode handshake bundle for the fetch unit.
interface instr_fetch_unit_if;

    logic                      redirect_valid;
    logic [fetch_pkg::XLEN-1:0] redirect_pc;
    logic                      imem_req_valid;
    logic [fetch_pkg::XLEN-1:0] imem_req_addr;
    logic                      imem_req_ready;
    logic                      imem_rsp_valid;
    logic [fetch_pkg::XLEN-1:0] imem_rsp_data;
    logic                      instr_valid;
    logic [fetch_pkg::XLEN-1:0] instr_data;
    logic [fetch_pkg::XLEN-1:0] instr_pc;
    logic                      instr_ready;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
        output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
        input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc
    );

endinterface

// File: rtl/fetch_queue.sv
// In-order FIFO of {pc, instr} entries; flush beats push.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output fetch_entry_t                 head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic            do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Credit-limited fetch stage with redirect flush; FETCH_PERF_CNT_EN adds perf counters.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_delivered,
    output logic [31:0]        perf_dropped,
    output logic [31:0]        perf_stall
`endif
);
    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_pc, tail_pc, redir_tgt;
    logic [CW-1:0]   outstanding, outstanding_nxt, drop, q_count;
    logic [CW:0]     credits_used;
    logic            accept, rsp, push, pop, q_full, q_empty;
    fetch_entry_t    q_head, push_entry;
    logic            unused_pc_lsb;

    assign unused_pc_lsb = ^bus.redirect_pc[1:0];
    assign redir_tgt     = {bus.redirect_pc[XLEN-1:2], 2'b00};

    // Outstanding fetches plus queued entries may never exceed the queue depth.
    assign credits_used       = {1'b0, outstanding} + {1'b0, q_count};
    assign bus.imem_req_valid = (state == RUN) && !rst && (credits_used < (CW+1)'(QDEPTH));
    assign bus.imem_req_addr  = fetch_pc;

    assign accept          = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp             = bus.imem_rsp_valid;
    assign pop             = bus.instr_valid && bus.instr_ready;
    assign push            = rsp && (drop == '0) && !bus.redirect_valid;
    assign outstanding_nxt = outstanding + CW'(accept) - CW'(rsp);
    assign push_entry      = '{pc: tail_pc, instr: bus.imem_rsp_data};

    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count),
        .head      (q_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            tail_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            state       <= RUN;
        end else begin
            outstanding <= outstanding_nxt;
            if (bus.redirect_valid) begin
                // Every request still in flight after this edge belongs to the old path.
                fetch_pc <= redir_tgt;
                tail_pc  <= redir_tgt;
                drop     <= outstanding_nxt;
                state    <= (outstanding_nxt != '0) ? FLUSH : RUN;
            end else begin
                if (accept)                fetch_pc <= fetch_pc + PC_STEP;
                if (push)                  tail_pc  <= tail_pc + PC_STEP;
                if (rsp && drop != '0)     drop     <= drop - 1'b1;
                if (state == FLUSH && drop == '0) state <= RUN;
            end
        end
    end

    assign bus.instr_valid = !q_empty;
    assign bus.instr_data  = q_empty ? INSTR_NOP : q_head.instr;
    assign bus.instr_pc    = q_empty ? '0 : q_head.pc;

    assert property (@(posedge clk) disable iff (rst) !(push && q_full && !pop));

`ifdef FETCH_PERF_CNT_EN
    logic          rsp_dropped;
    logic [CW-1:0] cleared;

    assign rsp_dropped = rsp && (bus.redirect_valid || drop != '0);
    assign cleared     = bus.redirect_valid ? q_count - CW'(pop) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_delivered <= '0;
            perf_dropped   <= '0;
            perf_stall     <= '0;
        end else begin
            perf_delivered <= sat_add(perf_delivered, 32'(pop));
            perf_dropped   <= sat_add(perf_dropped, 32'(rsp_dropped) + 32'(cleared));
            perf_stall     <= sat_add(perf_stall, 32'(bus.instr_ready && !bus.instr_valid));
        end
    end
`endif

endmodule
